// File: rtl/cdwu_pkg.sv
// Shared constants and helpers for the cdwu write scheduler.
package cdwu_pkg;

  localparam logic [1:0] SRC_I = 2'd0;
  localparam logic [1:0] SRC_D = 2'd1;
  localparam logic [1:0] SRC_C = 2'd2;

  // Width of an age counter able to hold 0..limit; never narrower than one bit.
  function automatic int cw_of(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cdwu_sched_if.sv
// Requester handshakes, stall input and registered bank write port of the scheduler.
interface cdwu_sched_if #(
  parameter int BANKBITS = 5,
  parameter int WORDBITS = 9,
  parameter int DATABITS = 32
);
  localparam int A = BANKBITS + WORDBITS;

  logic                i_valid, d_valid, c_valid;
  logic [A-1:0]        i_addr, d_addr, c_addr;
  logic [DATABITS-1:0] i_data, d_data, c_data;
  logic                i_ready, d_ready, c_ready;
  logic                stall;
  logic                o_en;
  logic [A-1:0]        o_addr;
  logic [DATABITS-1:0] o_data;
  logic [1:0]          muxcode;
  logic [1:0]          urgent;

  modport master (
    output i_valid, d_valid, c_valid, i_addr, d_addr, c_addr,
           i_data, d_data, c_data, stall,
    input  i_ready, d_ready, c_ready, o_en, o_addr, o_data, muxcode, urgent
  );

  modport slave (
    input  i_valid, d_valid, c_valid, i_addr, d_addr, c_addr,
           i_data, d_data, c_data, stall,
    output i_ready, d_ready, c_ready, o_en, o_addr, o_data, muxcode, urgent
  );
endinterface

// File: rtl/cdwu_age.sv
// Saturating wait counter for one requester; raises urgent one cycle after saturating.
module cdwu_age
  import cdwu_pkg::*;
#(
  parameter int LIMIT = 7,
  parameter int CW    = cw_of(LIMIT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid,
  input  logic grant,
  input  logic stall,
  output logic urgent
);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] count_r;
  logic          urgent_r;

  // Age update: frozen on stall, cleared on grant or withdrawn request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r  <= '0;
      urgent_r <= 1'b0;
    end else if (stall) begin
      count_r  <= count_r;
      urgent_r <= urgent_r;
    end else if (grant || !valid) begin
      count_r  <= '0;
      urgent_r <= 1'b0;
    end else begin
      if (count_r != LIM) begin
        count_r <= count_r + CW'(1);
      end else begin
        count_r <= count_r;
      end
      urgent_r <= (LIMIT != 0) && (count_r == LIM);
    end
  end

  assign urgent = urgent_r;
endmodule

// File: rtl/cdwu_sched.sv
// Three-way write-port scheduler: urgent d/c first, then fixed i > d > c, registered output.
module cdwu_sched
  import cdwu_pkg::*;
#(
  parameter int BANKBITS     = 5,
  parameter int WORDBITS     = 9,
  parameter int DATABITS     = 32,
  parameter int STARVE_LIMIT = 7
) (
  input logic         clk,
  input logic         rst_n,
  cdwu_sched_if.slave bus
);
  localparam int A = BANKBITS + WORDBITS;

  logic [2:0]          ready_s;   // {c, d, i}, one-hot or zero
  logic                d_urgent_s, c_urgent_s;
  logic [1:0]          src_s;
  logic [A-1:0]        addr_s;
  logic [DATABITS-1:0] data_s;

  logic                o_en_r;
  logic [A-1:0]        o_addr_r;
  logic [DATABITS-1:0] o_data_r;
  logic [1:0]          muxcode_r;

  // Grant arbitration.
  always_comb begin
    ready_s = 3'b000;
    if (!rst_n || bus.stall) begin
      ready_s = 3'b000;
    end else if (d_urgent_s && bus.d_valid) begin
      ready_s = 3'b010;
    end else if (c_urgent_s && bus.c_valid) begin
      ready_s = 3'b100;
    end else if (bus.i_valid) begin
      ready_s = 3'b001;
    end else if (bus.d_valid) begin
      ready_s = 3'b010;
    end else if (bus.c_valid) begin
      ready_s = 3'b100;
    end else begin
      ready_s = 3'b000;
    end
  end

  // Write-port source mux.
  always_comb begin
    src_s  = SRC_I;
    addr_s = bus.i_addr;
    data_s = bus.i_data;
    case (ready_s)
      3'b010: begin
        src_s  = SRC_D;
        addr_s = bus.d_addr;
        data_s = bus.d_data;
      end
      3'b100: begin
        src_s  = SRC_C;
        addr_s = bus.c_addr;
        data_s = bus.c_data;
      end
      default: begin
        src_s  = SRC_I;
        addr_s = bus.i_addr;
        data_s = bus.i_data;
      end
    endcase
  end

  // Output stage: address, data and source hold between grants.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_en_r    <= 1'b0;
      o_addr_r  <= '0;
      o_data_r  <= '0;
      muxcode_r <= SRC_I;
    end else if (|ready_s) begin
      o_en_r    <= 1'b1;
      o_addr_r  <= addr_s;
      o_data_r  <= data_s;
      muxcode_r <= src_s;
    end else begin
      o_en_r    <= 1'b0;
      o_addr_r  <= o_addr_r;
      o_data_r  <= o_data_r;
      muxcode_r <= muxcode_r;
    end
  end

  cdwu_age #(.LIMIT(STARVE_LIMIT)) u_age_d (
    .clk(clk), .rst_n(rst_n), .valid(bus.d_valid), .grant(ready_s[1]),
    .stall(bus.stall), .urgent(d_urgent_s)
  );

  cdwu_age #(.LIMIT(STARVE_LIMIT)) u_age_c (
    .clk(clk), .rst_n(rst_n), .valid(bus.c_valid), .grant(ready_s[2]),
    .stall(bus.stall), .urgent(c_urgent_s)
  );

  assign bus.i_ready = ready_s[0];
  assign bus.d_ready = ready_s[1];
  assign bus.c_ready = ready_s[2];
  assign bus.o_en    = o_en_r;
  assign bus.o_addr  = o_addr_r;
  assign bus.o_data  = o_data_r;
  assign bus.muxcode = muxcode_r;
  assign bus.urgent  = {c_urgent_s, d_urgent_s};
endmodule
